// File: rtl/l2_icache_pkg.sv
// l2_icache_pkg
//   Shared types and constants for the direct-mapped L2 instruction cache.
//   Contents:
//     L2_LINE_W / L2_LADDR_W  default line width and line-address width
//     state_t                 controller state encoding
//     tag_w() / set_w()       field widths of a line address {tag,set}
//   Optional feature macro: L2_NEXT_LINE_PREFETCH_EN adds the prefetch states.
package l2_icache_pkg;

  localparam int L2_LINE_W  = 128;
  localparam int L2_LADDR_W = 28;

`ifdef L2_NEXT_LINE_PREFETCH_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    REFILL   = 3'd2,
    RESPOND  = 3'd3,
    GAP      = 3'd4,
    PF_CHECK = 3'd5,
    PF_FILL  = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    REFILL   = 3'd2,
    RESPOND  = 3'd3,
    GAP      = 3'd4
  } state_t;
`endif

  function automatic int tag_w(input int laddr_w, input int set_bits);
    return laddr_w - set_bits;
  endfunction

  function automatic int set_w(input int set_bits);
    return set_bits;
  endfunction

endpackage

// File: rtl/l2_line_array.sv
// l2_line_array
//   Valid/tag/data storage for the direct-mapped L2 instruction cache.
//   Ports:
//     clk, reset            clock and synchronous active-high reset
//     rd_set                set index for the combinational read
//     rd_valid/tag/line     contents of the indexed set
//     wr_en/set/tag/line    synchronous line install (also sets valid)
//   Reset clears the valid bits only; tag and data storage keep their contents.
module l2_line_array
  import l2_icache_pkg::*;
#(
  parameter int SET_BITS = 5,
  parameter int TAG_W    = 23,
  parameter int LINE_W   = L2_LINE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SET_BITS-1:0] rd_set,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [LINE_W-1:0]   rd_line,
  input  logic                wr_en,
  input  logic [SET_BITS-1:0] wr_set,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [LINE_W-1:0]   wr_line
);

  localparam int NUM_SETS = 1 << set_w(SET_BITS);

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_set]  <= wr_tag;
      data_mem[wr_set] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_set];
  assign rd_tag   = tag_mem[rd_set];
  assign rd_line  = data_mem[rd_set];

endmodule

// File: rtl/l2_icache_dm.sv
// l2_icache_dm
//   Direct-mapped, read-only L2 instruction cache between the L1 miss port
//   and main memory. Hits answer two cycles after the request is seen;
//   misses refill the line from memory and then answer.
//   Ports:
//     clk, proc_reset        clock, synchronous active-high reset
//     l1_read/l1_addr        line read request (level, held until l1_ready)
//     l1_write/l1_wdata      unsupported, ignored
//     l1_rdata/l1_ready      one-cycle response; data is zero otherwise
//     mem_read/mem_addr      memory line request (level, held until ready)
//     mem_write/mem_wdata    tied to zero
//     mem_rdata/mem_ready    memory response, registered before use
//   Optional feature macro: L2_NEXT_LINE_PREFETCH_EN (next-line prefetch
//   after a refill).
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for l1_read; captures l1_addr into req_addr
//   LOOKUP   | tag compare on req_addr
//   REFILL   | memory read of req_addr until registered mem_ready
//   RESPOND  | one-cycle l1_ready with the line
//   GAP      | ignore a still-held l1_read for one cycle
//   PF_CHECK | (prefetch) test whether line req_addr+1 is present
//   PF_FILL  | (prefetch) fetch and install line req_addr+1
module l2_icache_dm
  import l2_icache_pkg::*;
#(
  parameter int SET_BITS = 5,
  parameter int LINE_W   = L2_LINE_W,
  parameter int LADDR_W  = L2_LADDR_W
) (
  input  logic               clk,
  input  logic               proc_reset,
  input  logic               l1_read,
  input  logic               l1_write,
  input  logic [LADDR_W-1:0] l1_addr,
  input  logic [LINE_W-1:0]  l1_wdata,
  output logic [LINE_W-1:0]  l1_rdata,
  output logic               l1_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic [LADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_ready
);

  localparam int TAG_W = tag_w(LADDR_W, SET_BITS);

  state_t             state, state_nxt;
  logic [LADDR_W-1:0] req_addr;
  logic               mem_ready_q;
  logic [LINE_W-1:0]  mem_rdata_q;

  logic [LADDR_W-1:0] lookup_addr;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [LINE_W-1:0]  rd_line;
  logic               hit;
  logic               fill_state;
  logic               wr_en;

  // Writes are not supported; these inputs are deliberately dropped.
  logic unused_l1_write;
  assign unused_l1_write = ^{l1_write, l1_wdata};

  assign mem_write = 1'b0;
  assign mem_wdata = '0;

`ifdef L2_NEXT_LINE_PREFETCH_EN
  logic was_miss;

  // PF_CHECK probes the next line before req_addr is advanced to it.
  assign lookup_addr = (state == PF_CHECK) ? req_addr + LADDR_W'(1) : req_addr;
  assign fill_state  = (state == REFILL) || (state == PF_FILL);
`else
  assign lookup_addr = req_addr;
  assign fill_state  = (state == REFILL);
`endif

  assign hit   = rd_valid && (rd_tag == lookup_addr[LADDR_W-1:SET_BITS]);
  // A reset in the same cycle as the memory response must not install the line.
  assign wr_en = fill_state && mem_ready_q && !proc_reset;

  l2_line_array #(
    .SET_BITS (SET_BITS),
    .TAG_W    (TAG_W),
    .LINE_W   (LINE_W)
  ) u_array (
    .clk      (clk),
    .reset    (proc_reset),
    .rd_set   (lookup_addr[SET_BITS-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_set   (req_addr[SET_BITS-1:0]),
    .wr_tag   (req_addr[LADDR_W-1:SET_BITS]),
    .wr_line  (mem_rdata_q)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state       <= IDLE;
      req_addr    <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      mem_ready_q <= mem_ready;
      mem_rdata_q <= mem_rdata;
      if (state == IDLE && l1_read) begin
        req_addr <= l1_addr;
      end
`ifdef L2_NEXT_LINE_PREFETCH_EN
      if (state == PF_CHECK) begin
        req_addr <= req_addr + LADDR_W'(1);
      end
`endif
    end
  end

`ifdef L2_NEXT_LINE_PREFETCH_EN
  // Remembers whether the transaction now responding came from a refill.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      was_miss <= 1'b0;
    end else if (state == LOOKUP) begin
      was_miss <= !hit;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    l1_ready  = 1'b0;
    l1_rdata  = '0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        if (l1_read) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        state_nxt = hit ? RESPOND : REFILL;
      end
      REFILL: begin
        if (mem_ready_q) begin
          state_nxt = RESPOND;
        end else begin
          mem_read = 1'b1;
          mem_addr = req_addr;
        end
      end
      RESPOND: begin
        l1_ready  = 1'b1;
        l1_rdata  = rd_line;
        state_nxt = GAP;
      end
      GAP: begin
`ifdef L2_NEXT_LINE_PREFETCH_EN
        state_nxt = was_miss ? PF_CHECK : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
`ifdef L2_NEXT_LINE_PREFETCH_EN
      PF_CHECK: begin
        state_nxt = hit ? IDLE : PF_FILL;
      end
      PF_FILL: begin
        if (mem_ready_q) begin
          state_nxt = IDLE;
        end else begin
          mem_read = 1'b1;
          mem_addr = req_addr;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_icache_dm.sv
module tb_l2_icache_dm;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         l1_read;
  logic         l1_write;
  logic [27:0]  l1_addr;
  logic [127:0] l1_wdata;
  logic [127:0] l1_rdata;
  logic         l1_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  always #5 clk = ~clk;

  l2_icache_dm dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .l1_read    (l1_read),
    .l1_write   (l1_write),
    .l1_addr    (l1_addr),
    .l1_wdata   (l1_wdata),
    .l1_rdata   (l1_rdata),
    .l1_ready   (l1_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    logic [127:0] data;
    int unsigned  start;
    int           lat;
    int           reqs;
    logic [27:0]  addr;
  } exp_t;

  exp_t        sbq[$];
  int unsigned resident[int];   // set index -> line address held there
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          mem_lat = 3;
  int          mem_reqs = 0;    // requests seen by the memory model
  int          model_reqs = 0;  // requests the reference model predicts
  int          rdata_leak = 0;
  int          wr_errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] mem_line(input logic [27:0] a);
    logic [31:0] x;
    x = {4'h0, a};
    return {x, ~x, x * 32'h9E3779B1, x ^ 32'h5A5A_5A5A};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory: answers a request mem_lat cycles after first seeing mem_read.
  initial begin : memory_model
    bit          busy;
    int          cnt;
    logic [27:0] cur;
    busy = 0; cnt = 0; cur = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (mem_write !== 1'b0 || mem_wdata !== '0) wr_errs++;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_line(cur);
          busy = 0;
        end
      end else if (mem_read) begin
        busy = 1;
        cur = mem_addr;
        cnt = mem_lat;
        mem_reqs++;
      end
    end
  end

  // Monitor: every l1_ready pops one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (l1_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready actual=1 required=0 at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("rdata@%h", e.addr), l1_rdata, e.data);
          chk($sformatf("latency@%h", e.addr), 128'(cyc - e.start), 128'(e.lat));
          chk($sformatf("mem_reqs@%h", e.addr), 128'(mem_reqs), 128'(e.reqs));
        end
      end else if (l1_rdata !== '0) begin
        rdata_leak++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit present(input logic [27:0] a);
    return resident.exists(int'(a[4:0])) && resident[int'(a[4:0])] == 32'(a);
  endfunction

  task automatic do_read(input logic [27:0] a, input bit hold_extra, input bit with_write);
    exp_t        e;
    bit          hit;
    int          t;
    logic [27:0] n;
    hit = present(a);
    if (!hit) begin
      resident[int'(a[4:0])] = 32'(a);
      model_reqs++;
    end
    e.addr = a;
    e.data = mem_line(a);
    e.lat  = hit ? 2 : mem_lat + 4;
    e.reqs = model_reqs;
`ifdef L2_NEXT_LINE_PREFETCH_EN
    if (!hit) begin
      n = a + 28'd1;
      if (!present(n)) begin
        resident[int'(n[4:0])] = 32'(n);
        model_reqs++;
      end
    end
`else
    n = '0;
`endif
    l1_read  = 1'b1;
    l1_write = with_write;
    l1_addr  = a;
    l1_wdata = {$urandom, $urandom, $urandom, $urandom};
    e.start  = cyc;
    sbq.push_back(e);
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (l1_ready !== 1'b1 && t < 60);
    if (l1_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL timeout@%h actual=no_ready required=ready within %0d cycles", a, t);
      l1_read  = 1'b0;
      l1_write = 1'b0;
      sbq.delete();
      idle(20);
      return;
    end
    @(posedge clk);
    #1;
    if (!hold_extra) begin
      l1_read  = 1'b0;
      l1_write = 1'b0;
    end
    @(posedge clk);
    #1;
    l1_read  = 1'b0;
    l1_write = 1'b0;
`ifdef L2_NEXT_LINE_PREFETCH_EN
    idle(mem_lat + 10);
`else
    idle(hit ? $urandom_range(0, 2) : 1);
`endif
  endtask

  // Resets the cache while a refill of address a is outstanding.
  task automatic reset_mid_refill(input logic [27:0] a);
    int t;
    l1_read = 1'b1;
    l1_addr = a;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (mem_read !== 1'b1 && t < 20);
    chk("refill_started", mem_read, 1'b1);
    chk("refill_addr", mem_addr, a);
    if (!present(a)) model_reqs++;
    @(posedge clk);
    #1;
    proc_reset = 1'b1;
    l1_read    = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_mem_read", mem_read, 1'b0);
    chk("reset_l1_ready", l1_ready, 1'b0);
    proc_reset = 1'b0;
    resident.delete();
    idle(mem_lat + 6);
  endtask

  logic [22:0] tag_pool [4];

  initial begin : stimulus
    proc_reset = 1'b1;
    l1_read    = 1'b0;
    l1_write   = 1'b0;
    l1_addr    = '0;
    l1_wdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_l1_ready", l1_ready, 1'b0);
    chk("reset_l1_rdata", l1_rdata, '0);
    chk("reset_mem_read", mem_read, 1'b0);
    chk("reset_mem_addr", mem_addr, '0);
    proc_reset = 1'b0;
    idle(2);

    mem_lat = 3;
    do_read(28'h0000010, 0, 0);   // cold miss, latency 7
    do_read(28'h0000010, 0, 0);   // hit, latency 2
    do_read(28'h0000030, 0, 0);   // conflict miss in set 16
    do_read(28'h0000010, 0, 0);   // evicted, misses again
    do_read(28'h0000010, 1, 0);   // L1 holds read through GAP
    do_read(28'h0000010, 0, 1);   // read+write treated as read
    l1_write = 1'b1;              // write alone starts nothing
    l1_addr  = 28'h0000055;
    idle(6);
    l1_write = 1'b0;
    idle(2);
    reset_mid_refill(28'h0000030);
    do_read(28'h0000030, 0, 0);
    do_read(28'h0000010, 0, 0);
    do_read(28'hFFFFFFF, 0, 0);   // wraps to line 0 when prefetching
    do_read(28'h0000000, 0, 0);

    tag_pool[0] = 23'h000000;
    tag_pool[1] = 23'h000001;
    tag_pool[2] = 23'h7FFFFF;
    tag_pool[3] = 23'h2A5A5A;
    for (int i = 0; i < 300; i++) begin
      logic [27:0] a;
      if (i % 50 == 0) mem_lat = $urandom_range(1, 5);
      a = {tag_pool[$urandom_range(0, 3)], 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 9) == 0) begin
        l1_write = 1'b1;
        l1_addr  = a;
        idle($urandom_range(1, 3));
        l1_write = 1'b0;
      end
      do_read(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    idle(10);
    chk("rdata_zero_outside_respond", 128'(rdata_leak), '0);
    chk("mem_write_tied_low", 128'(wr_errs), '0);
    chk("scoreboard_drained", 128'(sbq.size()), '0);
    chk("total_mem_requests", 128'(mem_reqs), 128'(model_reqs));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
